issue_port_arbiter: RTL

//   Shares one execution-unit issue port between NUM_REQ issue FIFOs (e.g. ALU0/ALU1/BRU queues).
//   - Round-robin selects a non-empty FIFO and pops it.
//   - Captures the head entry in a one-entry output register.
//   - Presents the entry to the FU with a valid/ready handshake.
//   - Supports full throughput (one issue per cycle) and pipeline flush.

---
 rtl/issue_port_arbiter_pkg.sv | 27 ++
 rtl/issue_port_arbiter_rr_picker.sv | 46 ++++
 rtl/issue_port_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/issue_port_arbiter_pkg.sv
// Shared types for the issue-port arbiter: the reservation-station entry
// carried from the issue FIFOs to the functional unit.
package issue_port_arbiter_pkg;

  localparam int unsigned OPC_W  = 8;
  localparam int unsigned ROB_W  = 6;
  localparam int unsigned PREG_W = 7;
  localparam int unsigned IMM_W  = 16;

  // Functional-unit class the entry was dispatched for.
  typedef enum logic [1:0] {
    FU_ALU0 = 2'd0,
    FU_ALU1 = 2'd1,
    FU_BRU  = 2'd2,
    FU_LSU  = 2'd3
  } fu_class_e;

  // One issue-queue entry as presented to the execution unit.
  typedef struct packed {
    fu_class_e         fu;
    logic [OPC_W-1:0]  opcode;
    logic [ROB_W-1:0]  rob_idx;
    logic [PREG_W-1:0] prd;
    logic [IMM_W-1:0]  imm;
  } RS_ENTRY_t;

endpackage

// File: rtl/issue_port_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the first requester at or
// above ptr_i, wrapping modulo N, as both a one-hot grant and an index.
module rr_picker #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          any_o
);

  logic [N-1:0]   at_or_above_ptr;
  logic [2*N-1:0] dbl_req;
  logic           found;

  // Low copy keeps only requesters at or above the pointer; the high copy
  // supplies the wrapped-around requesters below it.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    at_or_above_ptr = '0;
    for (int i = 0; i < N; i++) begin
      at_or_above_ptr[i] = (IW'(i) >= ptr_i);
    end
    dbl_req = {req_i, req_i & at_or_above_ptr};
  end

  // Priority-encode the lowest set bit of the doubled vector and fold it
  // back into the 0..N-1 range.
  always_comb begin
    found     = 1'b0;
    gnt_idx_o = '0;
    for (int j = 0; j < 2 * N; j++) begin
      if (!found && dbl_req[j]) begin
        found     = 1'b1;
        gnt_idx_o = (j >= N) ? IW'(j - N) : IW'(j);
      end
    end
    any_o = found;
    gnt_o = '0;
    if (found) gnt_o[gnt_idx_o] = 1'b1;
  end

endmodule

// File: rtl/issue_port_arbiter.sv
// Shares one execution-unit issue port between NUM_REQ issue FIFOs.
// A round-robin picker chooses a non-empty FIFO, pops it into a one-entry
// output register, and the entry is handed to the FU with valid/ready.
// Popping in the same cycle as a handshake gives one issue per cycle.
module issue_port_arbiter
  import issue_port_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic      [NUM_REQ-1:0]     fifo_empty,
  input  RS_ENTRY_t [NUM_REQ-1:0]     fifo_data,
  output logic      [NUM_REQ-1:0]     fifo_read_en,
  output logic                        issue_valid,
  output RS_ENTRY_t                   issue_entry,
  output logic      [SRC_W-1:0]       issue_src,
  input  logic                        issue_ready,
  output logic      [31:0]            grant_cnt
);

  logic                 valid_q,     valid_d;
  RS_ENTRY_t            entry_q,     entry_d;
  logic [SRC_W-1:0]     src_q,       src_d;
  logic [SRC_W-1:0]     rr_ptr_q,    rr_ptr_d;
  logic [31:0]          grant_cnt_q, grant_cnt_d;

  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   gnt;
  logic [SRC_W-1:0]     gnt_idx;
  logic                 gnt_any;
  logic                 slot_free;
  logic                 handshake;
  logic                 pop;

  assign req = ~fifo_empty;

  rr_picker #(.N(NUM_REQ)) u_picker (
    .req_i     (req),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (gnt_any)
  );

  // Pop whenever the output register is free or being drained this cycle;
  // flush and reset suppress the pop so no entry is lost from a FIFO.
  always_comb begin
    slot_free    = !valid_q || issue_ready;
    handshake    = valid_q && issue_ready;
    pop          = slot_free && gnt_any && !flush && rst_n;
    fifo_read_en = pop ? gnt : '0;
  end

  // Next state of the output register, round-robin pointer and grant counter.
  always_comb begin
    valid_d     = valid_q;
    entry_d     = entry_q;
    src_d       = src_q;
    rr_ptr_d    = rr_ptr_q;
    grant_cnt_d = grant_cnt_q;

    if (flush) begin
      valid_d = 1'b0;
    end else if (pop) begin
      valid_d  = 1'b1;
      entry_d  = fifo_data[gnt_idx];
      src_d    = gnt_idx;
      // Explicit wrap so a non-power-of-two NUM_REQ never relies on overflow.
      rr_ptr_d = (gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0 : gnt_idx + SRC_W'(1);
    end else if (handshake) begin
      valid_d = 1'b0;
    end

    if (handshake && !flush) begin
      grant_cnt_d = grant_cnt_q + 32'd1;
    end
  end

  // State registers; reset discards any entry held in the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the entry register is reset along with valid because its value
      // is directly visible on issue_entry, not just qualified by valid.
      valid_q     <= 1'b0;
      entry_q     <= '0;
      src_q       <= '0;
      rr_ptr_q    <= '0;
      grant_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      valid_q     <= valid_d;
      entry_q     <= entry_d;
      src_q       <= src_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign issue_valid = valid_q;
  assign issue_entry = entry_q;
  assign issue_src   = src_q;
  assign grant_cnt   = grant_cnt_q;

endmodule
